// File: rtl/wb_ctrl_sequencer.sv
// Frame-synchronous control sequencer for a white-balance corrector: mode changes, coefficient commits, calibration strobes.
// Defining WB_CTRL_SEQ_FRAME_CNT_EN adds a 16-bit start-of-frame counter on frame_cnt_o.
module wb_ctrl_sequencer #(
    parameter int unsigned COEF_WIDTH        = 20,
    parameter int unsigned FRACT_WIDTH       = 10,
    parameter int unsigned CAL_SETTLE_FRAMES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sof_tvalid_i,
    input  logic                  sof_tready_i,
    input  logic                  sof_tuser_i,
    input  logic                  mode_wr_i,
    input  logic [1:0]            mode_req_i,
    input  logic                  coef_wr_i,
    input  logic [1:0]            coef_sel_i,
    input  logic [COEF_WIDTH-1:0] coef_data_i,
    input  logic                  coef_commit_i,
    input  logic                  cal_req_i,
    output logic [1:0]            mode_o,
    output logic [1:0]            man_sel_o,
    output logic [COEF_WIDTH-1:0] man_coef_o,
    output logic                  man_lock_o,
    output logic                  cal_stb_o,
    output logic                  busy_o,
    output logic                  cal_done_o
`ifdef WB_CTRL_SEQ_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_cnt_o
`endif
);

    localparam int unsigned           CNT_WIDTH = 4;
    localparam logic [1:0]            MODE_CAL  = 2'd3;
    localparam logic [COEF_WIDTH-1:0] COEF_ONE  = COEF_WIDTH'(1) << FRACT_WIDTH;
    localparam logic [CNT_WIDTH-1:0]  SETTLE    = CNT_WIDTH'(CAL_SETTLE_FRAMES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_WR_R,
        ST_WR_G,
        ST_WR_B,
        ST_CAL_WAIT,
        ST_CAL_STB
    } state_t;

    state_t                state, state_nxt;
    logic                  sof;
    logic                  mode_pend_vld;
    logic [1:0]            mode_pend;
    logic [COEF_WIDTH-1:0] shadow_r, shadow_g, shadow_b;
    logic [COEF_WIDTH-1:0] snap_r, snap_g, snap_b;
    logic                  commit_pend, cal_pend;
    logic                  commit_clr, cal_clr;
    logic [CNT_WIDTH-1:0]  cal_cnt, cal_cnt_nxt, cal_cnt_inc;
    logic                  lock_nxt, stb_nxt, done_nxt;
    logic [1:0]            sel_nxt;
    logic [COEF_WIDTH-1:0] coef_nxt;

    assign sof         = sof_tvalid_i & sof_tready_i & sof_tuser_i;
    assign cal_cnt_inc = cal_cnt + CNT_WIDTH'(1);
    assign busy_o      = (state != ST_IDLE) | commit_pend | cal_pend;

    // Mode request is held pending and applied only at a frame boundary
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_o        <= 2'd0;
            mode_pend     <= 2'd0;
            mode_pend_vld <= 1'b0;
        end else begin
            if (sof && mode_pend_vld) begin
                mode_o <= mode_pend;
            end
            if (mode_wr_i) begin
                mode_pend     <= mode_req_i;
                mode_pend_vld <= 1'b1;
            end else if (sof) begin
                mode_pend_vld <= 1'b0;
            end
        end
    end

    // Shadow registers, commit snapshot and request flags; a new request wins over a clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_r    <= COEF_ONE;
            shadow_g    <= COEF_ONE;
            shadow_b    <= COEF_ONE;
            snap_r      <= COEF_ONE;
            snap_g      <= COEF_ONE;
            snap_b      <= COEF_ONE;
            commit_pend <= 1'b0;
            cal_pend    <= 1'b0;
        end else begin
            if (coef_wr_i) begin
                case (coef_sel_i)
                    2'd0:    shadow_r <= coef_data_i;
                    2'd1:    shadow_g <= coef_data_i;
                    2'd2:    shadow_b <= coef_data_i;
                    default: ;
                endcase
            end
            if (coef_commit_i) begin
                snap_r      <= shadow_r;
                snap_g      <= shadow_g;
                snap_b      <= shadow_b;
                commit_pend <= 1'b1;
            end else if (commit_clr) begin
                commit_pend <= 1'b0;
            end
            if (cal_req_i && (mode_o == MODE_CAL)) begin
                cal_pend <= 1'b1;
            end else if (cal_clr) begin
                cal_pend <= 1'b0;
            end
        end
    end

    // Next-state logic; registered outputs are derived from the next state so they align with it
    always_comb begin
        state_nxt   = state;
        cal_cnt_nxt = cal_cnt;
        commit_clr  = 1'b0;
        cal_clr     = 1'b0;
        lock_nxt    = 1'b0;
        stb_nxt     = 1'b0;
        done_nxt    = (state == ST_CAL_STB);
        sel_nxt     = man_sel_o;
        coef_nxt    = man_coef_o;

        case (state)
            ST_IDLE: begin
                if (commit_pend) begin
                    state_nxt = ST_WAIT_SOF;
                end else if (cal_pend) begin
                    state_nxt   = ST_CAL_WAIT;
                    cal_clr     = 1'b1;
                    cal_cnt_nxt = '0;
                end
            end
            ST_WAIT_SOF: begin
                if (sof) begin
                    state_nxt  = ST_WR_R;
                    commit_clr = 1'b1;
                end
            end
            ST_WR_R: state_nxt = ST_WR_G;
            ST_WR_G: state_nxt = ST_WR_B;
            ST_WR_B: state_nxt = ST_IDLE;
            ST_CAL_WAIT: begin
                if (mode_o != MODE_CAL) begin
                    state_nxt = ST_IDLE;
                end else if (sof) begin
                    cal_cnt_nxt = cal_cnt_inc;
                    if (cal_cnt_inc == SETTLE) begin
                        state_nxt = ST_CAL_STB;
                    end
                end
            end
            ST_CAL_STB: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase

        case (state_nxt)
            ST_WR_R: begin
                lock_nxt = 1'b1;
                sel_nxt  = 2'd0;
                coef_nxt = snap_r;
            end
            ST_WR_G: begin
                lock_nxt = 1'b1;
                sel_nxt  = 2'd1;
                coef_nxt = snap_g;
            end
            ST_WR_B: begin
                lock_nxt = 1'b1;
                sel_nxt  = 2'd2;
                coef_nxt = snap_b;
            end
            ST_CAL_STB: stb_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            cal_cnt    <= '0;
            man_lock_o <= 1'b0;
            man_sel_o  <= 2'd0;
            man_coef_o <= '0;
            cal_stb_o  <= 1'b0;
            cal_done_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            cal_cnt    <= cal_cnt_nxt;
            man_lock_o <= lock_nxt;
            man_sel_o  <= sel_nxt;
            man_coef_o <= coef_nxt;
            cal_stb_o  <= stb_nxt;
            cal_done_o <= done_nxt;
        end
    end

`ifdef WB_CTRL_SEQ_FRAME_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_o <= 16'd0;
        end else if (sof) begin
            frame_cnt_o <= frame_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_ctrl_sequencer.sv
// Self-checking bench for wb_ctrl_sequencer: directed vector table, reset-in-sequence case, randomized run vs. reference model.
module tb_wb_ctrl_sequencer;

    localparam int unsigned CW     = 20;
    localparam int unsigned FW     = 10;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned NVEC   = 36;
    localparam int unsigned NRAND  = 4000;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          sof_tvalid_i, sof_tready_i, sof_tuser_i;
    logic          mode_wr_i;
    logic [1:0]    mode_req_i;
    logic          coef_wr_i;
    logic [1:0]    coef_sel_i;
    logic [CW-1:0] coef_data_i;
    logic          coef_commit_i;
    logic          cal_req_i;
    logic [1:0]    mode_o, man_sel_o;
    logic [CW-1:0] man_coef_o;
    logic          man_lock_o, cal_stb_o, busy_o, cal_done_o;
`ifdef WB_CTRL_SEQ_FRAME_CNT_EN
    logic [15:0]   frame_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    wb_ctrl_sequencer #(
        .COEF_WIDTH       (CW),
        .FRACT_WIDTH      (FW),
        .CAL_SETTLE_FRAMES(SETTLE)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sof_tvalid_i (sof_tvalid_i),
        .sof_tready_i (sof_tready_i),
        .sof_tuser_i  (sof_tuser_i),
        .mode_wr_i    (mode_wr_i),
        .mode_req_i   (mode_req_i),
        .coef_wr_i    (coef_wr_i),
        .coef_sel_i   (coef_sel_i),
        .coef_data_i  (coef_data_i),
        .coef_commit_i(coef_commit_i),
        .cal_req_i    (cal_req_i),
        .mode_o       (mode_o),
        .man_sel_o    (man_sel_o),
        .man_coef_o   (man_coef_o),
        .man_lock_o   (man_lock_o),
        .cal_stb_o    (cal_stb_o),
        .busy_o       (busy_o),
        .cal_done_o   (cal_done_o)
`ifdef WB_CTRL_SEQ_FRAME_CNT_EN
        ,
        .frame_cnt_o  (frame_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          sof;
        logic          mwr;
        logic [1:0]    mreq;
        logic          cwr;
        logic [1:0]    csel;
        logic [CW-1:0] cdata;
        logic          commit;
        logic          cal;
        logic [CW+7:0] exp;
    } vec_t;

    vec_t tbl[NVEC];

    function automatic logic [CW+7:0] pk(input logic [1:0] md, input logic lk, input logic [1:0] sl,
                                         input logic [CW-1:0] cf, input logic sb, input logic dn, input logic by);
        return {md, lk, sl, cf, sb, dn, by};
    endfunction

    function automatic vec_t mk(input bit sof, input bit mwr, input int mreq, input bit cwr, input int csel,
                                input int cdata, input bit commit, input bit cal, input int emode, input bit elock,
                                input int esel, input int ecoef, input bit estb, input bit edone, input bit ebusy);
        vec_t v;
        v.sof = sof; v.mwr = mwr; v.mreq = 2'(mreq); v.cwr = cwr; v.csel = 2'(csel);
        v.cdata = CW'(cdata); v.commit = commit; v.cal = cal;
        v.exp = pk(2'(emode), elock, 2'(esel), CW'(ecoef), estb, edone, ebusy);
        return v;
    endfunction

    function automatic logic [CW+7:0] actual();
        return pk(mode_o, man_lock_o, man_sel_o, man_coef_o, cal_stb_o, cal_done_o, busy_o);
    endfunction

    task automatic check(input string name, input logic [CW+7:0] act, input logic [CW+7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got mode/lock/sel/coef/stb/done/busy=%h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sof, input bit mwr, input logic [1:0] mreq, input bit cwr,
                         input logic [1:0] csel, input logic [CW-1:0] cdata, input bit commit, input bit cal);
        sof_tvalid_i = sof; sof_tready_i = sof; sof_tuser_i = sof;
        mode_wr_i = mwr; mode_req_i = mreq; coef_wr_i = cwr; coef_sel_i = csel;
        coef_data_i = cdata; coef_commit_i = commit; cal_req_i = cal;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: pending requests as flags, write slots as a queue of channel indices
    logic [1:0]    m_mode, m_pmode, m_sel;
    logic [CW-1:0] m_shadow[3], m_snap[3], m_coef;
    bit            m_pvalid, m_commit, m_cal, awaiting, cal_active, slot_busy, cur_stb;
    bit            m_lock, m_stb, m_done;
    int            frames;
    int            wr_q[$];
    logic [15:0]   m_fcnt;

    task automatic model_reset();
        m_mode = 2'd0; m_pmode = 2'd0; m_pvalid = 0; m_commit = 0; m_cal = 0;
        awaiting = 0; cal_active = 0; slot_busy = 0; cur_stb = 0; frames = 0;
        m_lock = 0; m_stb = 0; m_done = 0; m_sel = 2'd0; m_coef = '0; m_fcnt = 16'd0;
        wr_q.delete();
        for (int k = 0; k < 3; k++) begin
            m_shadow[k] = CW'(1 << FW);
            m_snap[k]   = CW'(1 << FW);
        end
    endtask

    task automatic model_step(input bit sof, input bit mwr, input logic [1:0] mreq, input bit cwr,
                              input logic [1:0] csel, input logic [CW-1:0] cdata, input bit commit, input bit cal);
        bit         clr_commit = 0;
        bit         clr_cal    = 0;
        int         nxt_sel    = -1;
        bit         nxt_stb    = 0;
        logic [1:0] old_mode   = m_mode;
        m_done = cur_stb;
        if (slot_busy) begin
            if (wr_q.size() > 0) nxt_sel = wr_q.pop_front();
        end else if (awaiting) begin
            if (sof) begin
                awaiting = 0; clr_commit = 1; nxt_sel = 0;
                wr_q.push_back(1); wr_q.push_back(2);
            end
        end else if (cal_active) begin
            if (old_mode != 2'd3) cal_active = 0;
            else if (sof) begin
                frames++;
                if (frames == int'(SETTLE)) begin cal_active = 0; nxt_stb = 1; end
            end
        end else if (m_commit) begin
            awaiting = 1;
        end else if (m_cal) begin
            cal_active = 1; frames = 0; clr_cal = 1;
        end
        m_lock = (nxt_sel >= 0);
        if (m_lock) begin m_sel = 2'(nxt_sel); m_coef = m_snap[nxt_sel]; end
        m_stb = nxt_stb; cur_stb = nxt_stb; slot_busy = m_lock || nxt_stb;
        if (commit) begin
            m_commit = 1;
            for (int k = 0; k < 3; k++) m_snap[k] = m_shadow[k];
        end else if (clr_commit) m_commit = 0;
        if (cal && old_mode == 2'd3) m_cal = 1;
        else if (clr_cal) m_cal = 0;
        if (cwr && csel != 2'd3) m_shadow[csel] = cdata;
        if (sof && m_pvalid) begin m_mode = m_pmode; m_pvalid = 0; end
        if (mwr) begin m_pmode = mreq; m_pvalid = 1; end
        if (sof) m_fcnt = m_fcnt + 16'd1;
    endtask

    function automatic logic [CW+7:0] model_out();
        return pk(m_mode, m_lock, m_sel, m_coef, m_stb, m_done,
                  slot_busy || awaiting || cal_active || m_commit || m_cal);
    endfunction

    initial begin
        // sof mwr mreq cwr csel cdata commit cal | mode lock sel coef stb done busy
        tbl[0]  = mk(0,1,2,0,0,0,0,0,           0,0,0,0,0,0,0);
        tbl[1]  = mk(0,0,0,0,0,0,0,0,           0,0,0,0,0,0,0);
        tbl[2]  = mk(1,0,0,0,0,0,0,0,           2,0,0,0,0,0,0);
        tbl[3]  = mk(0,0,0,1,0,'h00477,0,0,     2,0,0,0,0,0,0);
        tbl[4]  = mk(0,0,0,1,1,'h00400,0,0,     2,0,0,0,0,0,0);
        tbl[5]  = mk(0,0,0,1,2,'h00827,0,0,     2,0,0,0,0,0,0);
        tbl[6]  = mk(0,0,0,1,3,'h12345,0,0,     2,0,0,0,0,0,0);
        tbl[7]  = mk(0,0,0,0,0,0,1,0,           2,0,0,0,0,0,1);
        tbl[8]  = mk(0,0,0,0,0,0,0,0,           2,0,0,0,0,0,1);
        tbl[9]  = mk(0,0,0,0,0,0,0,0,           2,0,0,0,0,0,1);
        tbl[10] = mk(1,0,0,0,0,0,0,0,           2,1,0,'h00477,0,0,1);
        tbl[11] = mk(0,0,0,0,0,0,0,0,           2,1,1,'h00400,0,0,1);
        tbl[12] = mk(0,0,0,0,0,0,0,0,           2,1,2,'h00827,0,0,1);
        tbl[13] = mk(0,0,0,0,0,0,0,0,           2,0,2,'h00827,0,0,0);
        tbl[14] = mk(0,1,3,0,0,0,0,0,           2,0,2,'h00827,0,0,0);
        tbl[15] = mk(1,0,0,0,0,0,0,0,           3,0,2,'h00827,0,0,0);
        tbl[16] = mk(0,0,0,0,0,0,0,1,           3,0,2,'h00827,0,0,1);
        tbl[17] = mk(0,0,0,0,0,0,0,0,           3,0,2,'h00827,0,0,1);
        tbl[18] = mk(1,0,0,0,0,0,0,0,           3,0,2,'h00827,0,0,1);
        tbl[19] = mk(0,0,0,0,0,0,0,0,           3,0,2,'h00827,0,0,1);
        tbl[20] = mk(1,0,0,0,0,0,0,0,           3,0,2,'h00827,1,0,1);
        tbl[21] = mk(0,0,0,0,0,0,0,0,           3,0,2,'h00827,0,1,0);
        tbl[22] = mk(0,0,0,0,0,0,0,0,           3,0,2,'h00827,0,0,0);
        tbl[23] = mk(0,0,0,0,0,0,1,1,           3,0,2,'h00827,0,0,1);
        tbl[24] = mk(0,0,0,0,0,0,0,0,           3,0,2,'h00827,0,0,1);
        tbl[25] = mk(1,0,0,0,0,0,0,0,           3,1,0,'h00477,0,0,1);
        tbl[26] = mk(0,0,0,0,0,0,0,0,           3,1,1,'h00400,0,0,1);
        tbl[27] = mk(0,0,0,0,0,0,0,0,           3,1,2,'h00827,0,0,1);
        tbl[28] = mk(0,0,0,0,0,0,0,0,           3,0,2,'h00827,0,0,1);
        tbl[29] = mk(0,1,0,0,0,0,0,0,           3,0,2,'h00827,0,0,1);
        tbl[30] = mk(1,0,0,0,0,0,0,0,           0,0,2,'h00827,0,0,1);
        tbl[31] = mk(0,0,0,0,0,0,0,0,           0,0,2,'h00827,0,0,0);
        tbl[32] = mk(1,0,0,0,0,0,0,0,           0,0,2,'h00827,0,0,0);
        tbl[33] = mk(0,0,0,0,0,0,0,0,           0,0,2,'h00827,0,0,0);
        tbl[34] = mk(0,0,0,0,0,0,0,1,           0,0,2,'h00827,0,0,0);
        tbl[35] = mk(0,0,0,0,0,0,0,0,           0,0,2,'h00827,0,0,0);

        rst_i = 1'b1;
        drive(0, 0, 2'd0, 0, 2'd0, '0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check("reset_state", actual(), pk(2'd0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < int'(NVEC); i++) begin
            drive(tbl[i].sof, tbl[i].mwr, tbl[i].mreq, tbl[i].cwr, tbl[i].csel,
                  tbl[i].cdata, tbl[i].commit, tbl[i].cal);
            step();
            check($sformatf("vec%0d", i), actual(), tbl[i].exp);
        end

        // Reset while the write sequence is in WR_G
        drive(0, 0, 2'd0, 0, 2'd0, '0, 1, 0); step();
        drive(0, 0, 2'd0, 0, 2'd0, '0, 0, 0); step(); step();
        drive(1, 0, 2'd0, 0, 2'd0, '0, 0, 0); step();
        drive(0, 0, 2'd0, 0, 2'd0, '0, 0, 0); step();
        check("pre_reset_wr_g", actual(), pk(2'd0, 1'b1, 2'd1, CW'('h00400), 1'b0, 1'b0, 1'b1));
        #2 rst_i = 1'b1;
        #1 check("reset_lock_drop", {27'd0, man_lock_o}, '0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i == 1, 0, 2'd0, 0, 2'd0, '0, 0, 0);
            step();
            check($sformatf("post_reset_idle%0d", i), actual(), pk(2'd0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0));
        end
        drive(0, 0, 2'd0, 0, 2'd0, '0, 1, 0); step();
        drive(0, 0, 2'd0, 0, 2'd0, '0, 0, 0); step(); step();
        drive(1, 0, 2'd0, 0, 2'd0, '0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            drive(0, 0, 2'd0, 0, 2'd0, '0, 0, 0);
            check($sformatf("reset_shadow_ch%0d", i), actual(),
                  pk(2'd0, 1'b1, 2'(i), CW'(1 << FW), 1'b0, 1'b0, 1'b1));
        end
        step();
        check("reset_shadow_done", actual(), pk(2'd0, 1'b0, 2'd2, CW'(1 << FW), 1'b0, 1'b0, 1'b0));

        // Randomized run against the reference model from a fresh reset
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        model_reset();
        for (int n = 0; n < int'(NRAND); n++) begin
            bit            tv, tr, tu, mwr, cwr, cm, cl;
            logic [1:0]    mreq, csel;
            logic [CW-1:0] cdata;
            tv = ($urandom_range(0, 3) != 0);
            tr = ($urandom_range(0, 3) != 0);
            tu = ($urandom_range(0, 4) == 0);
            mwr = ($urandom_range(0, 39) == 0);
            mreq = ($urandom_range(0, 9) < 6) ? 2'd3 : 2'($urandom_range(0, 2));
            cwr = ($urandom_range(0, 7) == 0);
            csel = 2'($urandom_range(0, 3));
            cdata = CW'($urandom);
            cm = ($urandom_range(0, 59) == 0);
            cl = ($urandom_range(0, 14) == 0);
            drive(0, mwr, mreq, cwr, csel, cdata, cm, cl);
            sof_tvalid_i = tv; sof_tready_i = tr; sof_tuser_i = tu;
            @(posedge clk_i);
            model_step(tv && tr && tu, mwr, mreq, cwr, csel, cdata, cm, cl);
            #1 check($sformatf("rand%0d", n), actual(), model_out());
        end
`ifdef WB_CTRL_SEQ_FRAME_CNT_EN
        check("frame_cnt", {12'd0, frame_cnt_o}, {12'd0, m_fcnt});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_ctrl_sequencer.md
WB_CTRL_SEQUENCER -- requirements
Module: wb_ctrl_sequencer

Interface
REQ-001 SHALL have parameter COEF_WIDTH, default 20, giving the fixed-point coefficient width (PX_WIDTH + FRACT_WIDTH).
REQ-002 SHALL have parameter FRACT_WIDTH, default 10, giving the fractional bits; fixed 1.0 = 1 << FRACT_WIDTH.
REQ-003 SHALL have parameter CAL_SETTLE_FRAMES, default 2, giving the frame starts to wait before a calibration strobe; legal range 1..15.
REQ-004 SHALL use one clock, clk_i, and an asynchronous active-high reset, rst_i, ports as follows:
- clk_i  in  1  clock
- rst_i  in  1  async reset, active-high
- sof_tvalid_i  in  1  tvalid of the monitored video stream
- sof_tready_i  in  1  tready of the monitored video stream
- sof_tuser_i  in  1  tuser (start of frame) of the monitored video stream
- mode_wr_i  in  1  one-cycle pulse requesting a mode change
- mode_req_i  in  2  requested mode: 0 auto gray-world, 1 auto retinex, 2 manual, 3 calibration
- coef_wr_i  in  1  shadow coefficient write strobe
- coef_sel_i  in  2  shadow select: 0 R, 1 G, 2 B, 3 ignored
- coef_data_i  in  COEF_WIDTH  shadow write data
- coef_commit_i  in  1  pulse requesting transfer of the shadow registers to the corrector
- cal_req_i  in  1  pulse requesting one calibration capture
- mode_o  out  2  applied mode
- man_sel_o  out  2  manual coefficient select
- man_coef_o  out  COEF_WIDTH  manual coefficient value
- man_lock_o  out  1  manual coefficient write enable
- cal_stb_o  out  1  calibration capture strobe
- busy_o  out  1  high whenever the FSM is not IDLE or a request is pending
- cal_done_o  out  1  one-cycle pulse after cal_stb_o

Function
REQ-005 SHALL define SOF as sof_tvalid_i && sof_tready_i && sof_tuser_i in one cycle.
REQ-006 SHALL latch mode_req_i on mode_wr_i into a pending register; a later mode_wr_i before the next SOF overwrites the pending value.
REQ-007 SHALL update mode_o only on the cycle after an SOF while a mode change is pending, so the mode never changes mid-frame.
REQ-008 SHALL write shadow[coef_sel_i] on coef_wr_i in any state; coef_sel_i = 3 has no effect.
REQ-009 SHALL, on coef_commit_i, snapshot all three shadow registers and set commit_pend; a second commit while commit_pend is set re-snapshots and holds a single pending commit.
REQ-010 SHALL implement FSM states IDLE, WAIT_SOF, WR_R, WR_G, WR_B, CAL_WAIT, CAL_STB.
REQ-011 SHALL transition IDLE->WAIT_SOF when commit_pend is set; WAIT_SOF->WR_R on SOF; WR_R->WR_G->WR_B->IDLE on consecutive cycles; commit_pend SHALL clear on entry to WR_R.
REQ-012 SHALL, in WR_R/WR_G/WR_B, drive man_lock_o=1, man_sel_o=0/1/2 and man_coef_o=snapshot R/G/B; otherwise man_lock_o=0 and man_sel_o/man_coef_o hold their last values.
REQ-013 SHALL set cal_pend on cal_req_i only when mode_o==3; otherwise cal_req_i is dropped.
REQ-014 SHALL transition IDLE->CAL_WAIT when cal_pend is set and commit_pend is clear (commit has priority when both are set); cal_pend SHALL clear on entry.
REQ-015 SHALL count SOFs in CAL_WAIT with a 4-bit counter cleared on entry; on the SOF that reaches CAL_SETTLE_FRAMES, go to CAL_STB.
REQ-016 SHALL assert cal_stb_o for exactly the CAL_STB cycle, assert cal_done_o for the following cycle, and return to IDLE.
REQ-017 SHALL abort CAL_WAIT to IDLE without cal_stb_o if mode_o leaves 3.
REQ-018 SHALL compute busy_o as (state != IDLE) || commit_pend || cal_pend.

Reset
REQ-019 SHALL, on rst_i: state=IDLE; mode_o=0; man_sel_o=0; man_coef_o=0; man_lock_o=0; cal_stb_o=0; cal_done_o=0; all pending flags and the counter cleared; shadow and snapshot registers = 1 << FRACT_WIDTH.
REQ-020 SHALL, when rst_i asserts mid-sequence (e.g. in WR_G), deassert man_lock_o immediately and not resume the sequence after reset.

Configuration
REQ-021 SHALL add output frame_cnt_o (16 bits) when WB_CTRL_SEQ_FRAME_CNT_EN is defined; it increments on every SOF, wraps 0xFFFF->0, and resets to 0. Without the macro the port and counter are absent and all other behaviour is unchanged.

Verification
REQ-022 Mode: mode_wr_i with 2 mid-frame -> mode_o stays 0 until the cycle after the next SOF, then 2.
REQ-023 Commit: shadow R=0x00477, G=0x00400, B=0x00827, then commit -> after the next SOF, three consecutive man_lock_o cycles with sel 0/1/2 carrying those values; busy_o low afterwards.
REQ-024 Calibration: mode_o=3, cal_req_i, default parameters -> cal_stb_o high for one cycle after the 2nd SOF, then cal_done_o for one cycle.
REQ-025 Priority and abort: commit and cal_req in the same cycle -> write sequence first, then CAL_WAIT; switching mode to 0 during CAL_WAIT -> no cal_stb_o.
REQ-026 Reset: rst_i asserted in WR_G -> man_lock_o=0 at once; after release, state is IDLE and the shadow registers read 0x00400.
